// File: rtl/pool1_lii_packer_pkg.sv
// Shared LII definitions: link width, id type and packer FSM states.
package pool1_lii_packer_pkg;

  localparam int LII_PW   = 64;
  localparam int LII_ID_W = 8;

  typedef logic [LII_ID_W-1:0] lii_id_t;

  typedef enum logic [0:0] {
    PACK  = 1'b0,
    FLUSH = 1'b1
  } pack_state_e;

endpackage

// File: rtl/pool1_lii_packer_if.sv
// One LII stream: AXIS-style data/valid/ready plus source and destination ids.
interface pool1_lii_packer_if;
  import pool1_lii_packer_pkg::*;

  logic [LII_PW-1:0] tdata;
  logic              tvalid;
  logic              tready;
  lii_id_t           src;
  lii_id_t           dst;

  modport master (output tdata, output tvalid, output src, output dst, input tready);
  modport slave  (input tdata, input tvalid, input src, input dst, output tready);

endinterface

// File: rtl/pool1_lii_packer_out_reg.sv
// 1-deep valid/ready output register carrying a beat, its ids and a frame-last marker.
module pool1_lii_packer_out_reg
  import pool1_lii_packer_pkg::*;
#(
  parameter int PW = LII_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [PW-1:0] tdata_i,
  input  lii_id_t       src_i,
  input  lii_id_t       dst_i,
  input  logic          last_i,
  input  logic          tready_i,
  output logic          tvalid_o,
  output logic [PW-1:0] tdata_o,
  output lii_id_t       src_o,
  output lii_id_t       dst_o,
  output logic          last_o,
  output logic          slot_free_o
);

  logic          tvalid_q;
  logic [PW-1:0] tdata_q;
  lii_id_t       src_q;
  lii_id_t       dst_q;
  logic          last_q;

  assign slot_free_o = !tvalid_q || tready_i;

  // Load wins over drain so beats can stream back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      last_q   <= 1'b0;
    end else if (load_i) begin
      tvalid_q <= 1'b1;
      tdata_q  <= tdata_i;
      src_q    <= src_i;
      dst_q    <= dst_i;
      last_q   <= last_i;
    end else if (tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  assign tvalid_o = tvalid_q;
  assign tdata_o  = tdata_q;
  assign src_o    = src_q;
  assign dst_o    = dst_q;
  assign last_o   = last_q;

endmodule

// File: rtl/pool1_lii_packer.sv
// Packs WW-bit words (one per input beat) densely LSB-first into PW-bit LII beats,
// zero-padding and flushing any partial beat at the end of each frame.
module pool1_lii_packer
  import pool1_lii_packer_pkg::*;
#(
  parameter int PW          = LII_PW,
  parameter int WW          = 48,
  parameter int FRAME_WORDS = 196
) (
  input  logic               aclk,
  input  logic               arst,
  pool1_lii_packer_if.slave  lii_in,
  pool1_lii_packer_if.master lii_out,
  output logic               frame_done
);

  localparam int CW = $clog2(PW) + 1;
  localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  pack_state_e   state_q;
  logic [PW-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] word_idx_q;
  lii_id_t       src_q;
  lii_id_t       dst_q;

  logic [WW-1:0]   word;
  logic [2*PW-1:0] ext_word;
  logic [2*PW-1:0] pk_w;
  logic [CW-1:0]   cnt_sum;
  logic [CW-1:0]   cnt_d;
  logic            full;
  logic            slot_free;
  logic            accept;
  logic            first_word;
  logic            last_word;
  logic            load;
  logic            load_last;
  logic [PW-1:0]   load_data;
  lii_id_t         load_src;
  lii_id_t         load_dst;
  logic            out_last;
  logic            unused_hi;

  assign word      = lii_in.tdata[WW-1:0];
  assign unused_hi = ^lii_in.tdata[PW-1:WW];

  assign ext_word = {{(2*PW-WW){1'b0}}, word};
  assign pk_w     = {{PW{1'b0}}, acc_q} | (ext_word << cnt_q);
  assign cnt_sum  = cnt_q + CW'(WW);
  assign full     = cnt_sum >= CW'(PW);
  assign cnt_d    = full ? (cnt_sum - CW'(PW)) : cnt_sum;

  // A word that fits in the residual is taken even while the output slot is busy.
  assign lii_in.tready = (state_q == PACK) && (!full || slot_free);
  assign accept        = lii_in.tvalid && lii_in.tready;
  assign first_word    = (word_idx_q == '0);
  assign last_word     = (word_idx_q == IW'(FRAME_WORDS - 1));

  always_comb begin
    load      = accept && full;
    load_data = pk_w[PW-1:0];
    load_src  = first_word ? lii_in.src : src_q;
    load_dst  = first_word ? lii_in.dst : dst_q;
    load_last = last_word && (cnt_d == '0);
    if (state_q == FLUSH) begin
      load      = slot_free;
      load_data = acc_q;
      load_src  = src_q;
      load_dst  = dst_q;
      load_last = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q    <= PACK;
      acc_q      <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      src_q      <= '0;
      dst_q      <= '0;
    end else begin
      case (state_q)
        PACK: begin
          if (accept) begin
            acc_q <= full ? pk_w[2*PW-1:PW] : pk_w[PW-1:0];
            cnt_q <= cnt_d;
            if (first_word) begin
              src_q <= lii_in.src;
              dst_q <= lii_in.dst;
            end
            // A residual at frame end must leave alone so the next frame starts on a fresh beat.
            if (last_word) begin
              word_idx_q <= '0;
              if (cnt_d != '0) state_q <= FLUSH;
            end else begin
              word_idx_q <= word_idx_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= PACK;
          end
        end
        default: state_q <= PACK;
      endcase
    end
  end

  pool1_lii_packer_out_reg #(.PW(PW)) u_out_reg (
    .clk         (aclk),
    .rst         (arst),
    .load_i      (load),
    .tdata_i     (load_data),
    .src_i       (load_src),
    .dst_i       (load_dst),
    .last_i      (load_last),
    .tready_i    (lii_out.tready),
    .tvalid_o    (lii_out.tvalid),
    .tdata_o     (lii_out.tdata),
    .src_o       (lii_out.src),
    .dst_o       (lii_out.dst),
    .last_o      (out_last),
    .slot_free_o (slot_free)
  );

  assign frame_done = lii_out.tvalid && lii_out.tready && out_last;

endmodule

// File: tb/tb_pool1_lii_packer.sv
// Scoreboard bench: two packers (196-word and 5-word frames) driven in turn from one stimulus stream.
module tb_pool1_lii_packer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic [7:0]  t;
    logic        last;
  } beat_t;

  logic clk;
  logic arst;
  logic sel;
  logic [63:0] din;
  logic        din_vld;
  logic [7:0]  din_src;
  logic [7:0]  din_dst;
  logic        out_rdy;
  logic        rnd_rdy;
  logic        a_fd;
  logic        b_fd;

  int checks = 0;
  int errors = 0;
  int beats[2];
  int fdc[2];
  bit prev_stall[2];
  logic [79:0] prev_v[2];

  beat_t qa[$];
  beat_t qb[$];
  bit          m_bits[$];
  int          m_idx;
  int          fw;
  logic [7:0]  m_src;
  logic [7:0]  m_dst;

  pool1_lii_packer_if a_in ();
  pool1_lii_packer_if a_out ();
  pool1_lii_packer_if b_in ();
  pool1_lii_packer_if b_out ();

  assign a_in.tdata   = din;
  assign a_in.src     = din_src;
  assign a_in.dst     = din_dst;
  assign a_in.tvalid  = din_vld & ~sel;
  assign b_in.tdata   = din;
  assign b_in.src     = din_src;
  assign b_in.dst     = din_dst;
  assign b_in.tvalid  = din_vld & sel;
  assign a_out.tready = out_rdy;
  assign b_out.tready = out_rdy;

  pool1_lii_packer #(.PW(64), .WW(48), .FRAME_WORDS(196)) dut_a (
    .aclk(clk), .arst(arst), .lii_in(a_in), .lii_out(a_out), .frame_done(a_fd)
  );

  pool1_lii_packer #(.PW(64), .WW(48), .FRAME_WORDS(5)) dut_b (
    .aclk(clk), .arst(arst), .lii_in(b_in), .lii_out(b_out), .frame_done(b_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic void push_exp(input logic which, input logic [63:0] d, input logic [7:0] s,
                                   input logic [7:0] t, input logic last);
    beat_t e;
    e.d = d; e.s = s; e.t = t; e.last = last;
    if (which) qb.push_back(e);
    else qa.push_back(e);
  endfunction

  // Bit-serial reference: words go in LSB-first, beats come out 64 bits at a time.
  task automatic model_word(input logic [47:0] w, input logic [7:0] s, input logic [7:0] t);
    logic [63:0] b;
    bit last;
    int k;
    if (m_idx == 0) begin m_src = s; m_dst = t; end
    for (int i = 0; i < 48; i++) m_bits.push_back(w[i]);
    m_idx++;
    last = (m_idx == fw);
    while (m_bits.size() >= 64) begin
      for (int i = 0; i < 64; i++) b[i] = m_bits.pop_front();
      push_exp(sel, b, m_src, m_dst, last && (m_bits.size() == 0));
    end
    if (last) begin
      if (m_bits.size() > 0) begin
        b = '0;
        k = 0;
        while (m_bits.size() > 0) begin b[k] = m_bits.pop_front(); k++; end
        push_exp(sel, b, m_src, m_dst, 1'b1);
      end
      m_idx = 0;
    end
  endtask

  task automatic send(input logic [47:0] w, input logic [7:0] s, input logic [7:0] t,
                      input bit use_model, input int gap);
    int n;
    bit hs;
    din = {16'hDEAD, w};
    din_src = s;
    din_dst = t;
    din_vld = 1'b1;
    n = 0;
    hs = 0;
    while (!hs) begin
      @(negedge clk);
      hs = sel ? b_in.tready : a_in.tready;
      @(posedge clk);
      #1;
      n++;
      if (!hs && n > 2000) begin
        $display("FAIL send_timeout sel=%0d ready stuck low", sel);
        errors++;
        $fatal(1, "input handshake never completed");
      end
    end
    din_vld = 1'b0;
    if (use_model) begin
      model_word(w, s, t);
    end else begin
      if (m_idx == 0) begin m_src = s; m_dst = t; end
      m_idx++;
      if (m_idx == fw) m_idx = 0;
    end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input logic which);
    int n;
    n = 0;
    while ((which ? qb.size() : qa.size()) != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ((which ? qb.size() : qa.size()) != 0) begin
      errors++;
      $display("FAIL drain%0d pending=%0d required=0", which, which ? qb.size() : qa.size());
    end
  endtask

  task automatic mon(input int which, input logic [63:0] d, input logic [7:0] s, input logic [7:0] t,
                     input logic v, input logic r, input logic fd);
    beat_t e;
    if (v && r) begin
      beats[which]++;
      if (fd) fdc[which]++;
      checks++;
      if ((which == 1) ? (qb.size() == 0) : (qa.size() == 0)) begin
        errors++;
        $display("FAIL beat%0d_unexpected got d=%h s=%0d t=%0d", which, d, s, t);
      end else begin
        e = (which == 1) ? qb.pop_front() : qa.pop_front();
        if (d !== e.d || s !== e.s || t !== e.t || fd !== e.last) begin
          errors++;
          $display("FAIL beat%0d got d=%h s=%0d t=%0d done=%b exp d=%h s=%0d t=%0d done=%b",
                   which, d, s, t, fd, e.d, e.s, e.t, e.last);
        end
      end
    end else if (fd) begin
      checks++;
      errors++;
      $display("FAIL done%0d_no_handshake got=1 exp=0", which);
    end
    if (prev_stall[which] && v) begin
      checks++;
      if ({d, s, t} !== prev_v[which]) begin
        errors++;
        $display("FAIL stall%0d_stable got=%h exp=%h", which, {d, s, t}, prev_v[which]);
      end
    end
    prev_stall[which] = v && !r;
    prev_v[which] = {d, s, t};
  endtask

  always @(negedge clk) begin
    if (arst) begin
      prev_stall[0] = 0;
      prev_stall[1] = 0;
    end else begin
      mon(0, a_out.tdata, a_out.src, a_out.dst, a_out.tvalid, a_out.tready, a_fd);
      mon(1, b_out.tdata, b_out.src, b_out.dst, b_out.tvalid, b_out.tready, b_fd);
    end
  end

  initial begin
    logic [47:0] w;
    sel = 0; din = '0; din_vld = 0; din_src = '0; din_dst = '0;
    rnd_rdy = 0; out_rdy = 1; arst = 1;
    m_idx = 0; fw = 196; m_src = '0; m_dst = '0;
    beats[0] = 0; beats[1] = 0; fdc[0] = 0; fdc[1] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", {63'd0, a_out.tvalid}, 64'd0);
    chk("rst_tdata", a_out.tdata, 64'd0);
    chk("rst_src_dst", {48'd0, a_out.src, a_out.dst}, 64'd0);
    chk("rst_frame_done", {62'd0, a_fd, b_fd}, 64'd0);
    @(posedge clk);
    #1;
    arst = 0;
    chk("idle_in_tready", {63'd0, a_in.tready}, 64'd1);

    // Frame 1: hand-computed beats for the first four words, ids latched from word 0 only.
    push_exp(0, 64'h2222_1111_1111_1111, 8'd3, 8'd7, 1'b0);
    push_exp(0, 64'h3333_3333_2222_2222, 8'd3, 8'd7, 1'b0);
    push_exp(0, 64'h4444_4444_4444_3333, 8'd3, 8'd7, 1'b0);
    send(48'h1111_1111_1111, 8'd3, 8'd7, 0, 0);
    send(48'h2222_2222_2222, 8'd9, 8'd9, 0, 0);
    send(48'h3333_3333_3333, 8'd9, 8'd9, 0, 0);
    send(48'h4444_4444_4444, 8'd9, 8'd9, 0, 0);
    for (int i = 4; i < 196; i++) begin
      w = {16'($urandom), 32'($urandom)};
      send(w, 8'd9, 8'd9, 1, 0);
    end
    wait_drain(0);
    chk("frame1_beats", 64'(beats[0]), 64'd147);
    chk("frame1_done_count", 64'(fdc[0]), 64'd1);

    // Frame 2: random backpressure and input gaps, new ids.
    rnd_rdy = 1;
    for (int i = 0; i < 196; i++) begin
      w = {16'($urandom), 32'($urandom)};
      send(w, (i == 0) ? 8'd9 : 8'hAA, (i == 0) ? 8'd4 : 8'hBB, 1, int'($urandom_range(0, 1)));
    end
    wait_drain(0);
    rnd_rdy = 0;
    out_rdy = 1;
    chk("frame2_beats", 64'(beats[0]), 64'd294);
    chk("frame2_done_count", 64'(fdc[0]), 64'd2);

    // Reset after two words with the output stalled: the pending beat is discarded.
    out_rdy = 0;
    send(48'hABCD_0000_0001, 8'd1, 8'd1, 1, 0);
    send(48'hABCD_0000_0002, 8'd1, 8'd1, 1, 0);
    chk("pre_reset_tvalid", {63'd0, a_out.tvalid}, 64'd1);
    arst = 1;
    @(posedge clk);
    #1;
    qa.delete();
    m_bits.delete();
    m_idx = 0;
    arst = 0;
    chk("post_reset_tvalid", {63'd0, a_out.tvalid}, 64'd0);
    chk("post_reset_tdata", a_out.tdata, 64'd0);
    out_rdy = 1;
    repeat (4) begin @(posedge clk); #1; end
    chk("post_reset_no_beat", 64'(beats[0]), 64'd294);
    for (int i = 0; i < 196; i++) begin
      w = {16'($urandom), 32'($urandom)};
      send(w, (i == 0) ? 8'd5 : 8'd0, (i == 0) ? 8'd6 : 8'd0, 1, 0);
    end
    wait_drain(0);
    chk("frame3_beats", 64'(beats[0]), 64'd441);
    chk("frame3_done_count", 64'(fdc[0]), 64'd3);

    // 5-word frames: 240 bits leave a 48-bit residual that is flushed with zero padding.
    sel = 1;
    fw = 5;
    m_idx = 0;
    push_exp(1, 64'h2222_1111_1111_1111, 8'd1, 8'd2, 1'b0);
    push_exp(1, 64'h3333_3333_2222_2222, 8'd1, 8'd2, 1'b0);
    push_exp(1, 64'h4444_4444_4444_3333, 8'd1, 8'd2, 1'b0);
    push_exp(1, 64'h0000_5555_5555_5555, 8'd1, 8'd2, 1'b1);
    send(48'h1111_1111_1111, 8'd1, 8'd2, 0, 0);
    send(48'h2222_2222_2222, 8'd1, 8'd2, 0, 0);
    send(48'h3333_3333_3333, 8'd1, 8'd2, 0, 0);
    send(48'h4444_4444_4444, 8'd1, 8'd2, 0, 0);
    send(48'h5555_5555_5555, 8'd1, 8'd2, 0, 0);
    chk("flush_in_tready", {63'd0, b_in.tready}, 64'd0);
    @(posedge clk);
    #1;
    chk("after_flush_in_tready", {63'd0, b_in.tready}, 64'd1);
    rnd_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      w = {16'($urandom), 32'($urandom)};
      send(w, (i < 5) ? 8'd11 : 8'd12, (i < 5) ? 8'd21 : 8'd22, 1, int'($urandom_range(0, 1)));
    end
    wait_drain(1);
    rnd_rdy = 0;
    out_rdy = 1;
    chk("short_frames_beats", 64'(beats[1]), 64'd12);
    chk("short_frames_done", 64'(fdc[1]), 64'd3);
    chk("a_idle_during_b", 64'(beats[0]), 64'd441);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
